// File: rtl/imem_arbiter.sv
// Port arbiter and boot sequencer for the single-port instruction BRAM.
// LOAD hands the port to the loader; RUN serves fetches and interleaves loader patches.
module imem_arbiter #(
  parameter int ADDR_W       = 10,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_gnt,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] fetch_data,
  input  logic              load_valid,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  input  logic              reload,
  output logic              cpu_hold,
  output logic [ADDR_W:0]   load_count,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);
  localparam logic [ADDR_W:0]  COUNT_MAX  = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [CNT_W-1:0]  starve_cnt;
  logic              forced;
  logic              load_hs;
  logic [ADDR_W-1:0] addr_hold;
  logic [DATA_W-1:0] wdata_hold;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_LOAD;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_LOAD: if (load_hs && load_last) state_next = ST_RUN;
      ST_RUN:  if (reload) state_next = ST_LOAD;
      default: state_next = ST_LOAD;
    endcase
  end

  assign forced = (starve_cnt == STARVE_MAX);

  // Output logic: fetch wins in RUN unless the loader has waited STARVE_LIMIT cycles
  always_comb begin
    fetch_gnt  = 1'b0;
    load_ready = 1'b1;
    case (state)
      ST_LOAD: begin
        fetch_gnt  = 1'b0;
        load_ready = 1'b1;
      end
      ST_RUN: begin
        if (reload) begin
          load_ready = 1'b0;
        end else begin
          fetch_gnt  = fetch_req & ~forced;
          load_ready = ~fetch_req | forced;
        end
      end
      default: begin
        fetch_gnt  = 1'b0;
        load_ready = 1'b1;
      end
    endcase
  end

  // rst_n gating keeps the BRAM quiet while reset is held, even with load_valid high
  assign load_hs = load_valid & load_ready & rst_n;
  assign mem_we  = load_hs;

  // Idle cycles re-present the last address so the BRAM sees no new activity
  always_comb begin
    mem_addr  = addr_hold;
    mem_wdata = wdata_hold;
    if (load_hs) begin
      mem_addr  = load_addr;
      mem_wdata = load_data;
    end else if (fetch_gnt) begin
      mem_addr = fetch_addr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_hold  <= '0;
      wdata_hold <= '0;
    end else if (load_hs) begin
      addr_hold  <= load_addr;
      wdata_hold <= load_data;
    end else if (fetch_gnt) begin
      addr_hold <= fetch_addr;
    end
  end

  // Cannot pass STARVE_MAX: at the limit the loader is granted, which clears it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if ((state == ST_RUN) && !reload && load_valid && !load_ready) begin
      starve_cnt <= starve_cnt + 1'b1;
    end else begin
      starve_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_hold <= 1'b1;
    end else begin
      cpu_hold <= (state_next == ST_LOAD);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_valid <= 1'b0;
    end else begin
      fetch_valid <= fetch_gnt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_count <= '0;
    end else if ((state == ST_RUN) && reload) begin
      load_count <= '0;
    end else if ((state == ST_LOAD) && load_hs && (load_count != COUNT_MAX)) begin
      load_count <= load_count + 1'b1;
    end
  end

  assign fetch_data = mem_rdata;

endmodule

// File: tb/tb_imem_arbiter.sv
// Bench for imem_arbiter: BRAM model, reference memory image and a fetch scoreboard.
module tb_imem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_req;
  logic [9:0]  fetch_addr;
  logic        fetch_gnt;
  logic        fetch_valid;
  logic [31:0] fetch_data;
  logic        load_valid;
  logic [9:0]  load_addr;
  logic [31:0] load_data;
  logic        load_last;
  logic        load_ready;
  logic        reload;
  logic        cpu_hold;
  logic [10:0] load_count;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;

  int checks = 0;
  int errors = 0;

  logic [31:0] bram  [1024];
  logic [31:0] model [1024];
  logic [31:0] exp_q [$];
  logic [31:0] mon_exp;

  imem_arbiter #(.ADDR_W(10), .DATA_W(32), .STARVE_LIMIT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
    .fetch_valid(fetch_valid), .fetch_data(fetch_data),
    .load_valid(load_valid), .load_addr(load_addr), .load_data(load_data),
    .load_last(load_last), .load_ready(load_ready), .reload(reload),
    .cpu_hold(cpu_hold), .load_count(load_count),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Single-port BRAM, registered read, write-first
  always @(posedge clk) begin
    if (mem_we) begin
      bram[mem_addr] <= mem_wdata;
      mem_rdata      <= mem_wdata;
    end else begin
      mem_rdata <= bram[mem_addr];
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_cycle(input logic [9:0] a, input logic exp_gnt);
    fetch_req  = 1'b1;
    fetch_addr = a;
    @(negedge clk);
    check("fetch_gnt", fetch_gnt, exp_gnt);
    @(posedge clk);
    if (exp_gnt) exp_q.push_back(model[a]);
    #1;
  endtask

  // Every cycle: a pending expected instruction must appear, otherwise fetch_valid stays low
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_exp = exp_q.pop_front();
      check("fetch_valid", fetch_valid, 1);
      check("fetch_data", fetch_data, mon_exp);
      $display("fetch data=%08h expected=%08h", fetch_data, mon_exp);
    end else begin
      check("fetch_valid_idle", fetch_valid, 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    rst_n = 1'b0; fetch_req = 1'b0; fetch_addr = '0; load_valid = 1'b0;
    load_addr = '0; load_data = '0; load_last = 1'b0; reload = 1'b0;
    for (int i = 0; i < 1024; i++) model[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cpu_hold", cpu_hold, 1);
    check("rst_fetch_valid", fetch_valid, 0);
    check("rst_load_count", load_count, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_fetch_gnt", fetch_gnt, 0);
    check("rst_load_ready", load_ready, 1);
    rst_n = 1'b1;
    tick();

    // Boot load of 4 words, then fetch them back
    for (int i = 0; i < 4; i++) begin
      load_valid = 1'b1; load_addr = 10'(i); load_data = 32'h13 + 32'(i); load_last = (i == 3);
      @(negedge clk);
      check("boot_ready", load_ready, 1);
      check("boot_we", mem_we, 1);
      check("boot_addr", mem_addr, i);
      check("boot_wdata", mem_wdata, 32'h13 + 32'(i));
      check("boot_hold", cpu_hold, 1);
      check("boot_count", load_count, i);
      @(posedge clk);
      model[i] = 32'h13 + 32'(i);
      #1;
    end
    load_valid = 1'b0; load_last = 1'b0;
    fetch_req = 1'b1; fetch_addr = 10'd0;
    @(negedge clk);
    check("run_hold", cpu_hold, 0);
    check("run_count", load_count, 4);
    check("first_gnt", fetch_gnt, 1);
    check("first_addr", mem_addr, 0);
    @(posedge clk);
    exp_q.push_back(model[0]);
    #1;
    for (int i = 1; i < 4; i++) fetch_cycle(10'(i), 1'b1);
    fetch_req = 1'b0;
    @(negedge clk);
    check("idle_we", mem_we, 0);
    check("idle_addr_hold", mem_addr, 3);
    tick();

    // Starvation: loader forced in on the 9th cycle of continuous fetch
    for (int k = 1; k <= 12; k++) begin
      fetch_req = 1'b1; fetch_addr = 10'(k % 4);
      load_valid = (k <= 9); load_addr = 10'd2; load_data = 32'hDEADBEEF;
      @(negedge clk);
      check("starve_gnt", fetch_gnt, k != 9);
      check("starve_ready", load_ready, k == 9);
      check("starve_we", mem_we, k == 9);
      @(posedge clk);
      if (k == 9) model[2] = 32'hDEADBEEF;
      else exp_q.push_back(model[k % 4]);
      #1;
    end
    load_valid = 1'b0;
    fetch_cycle(10'd2, 1'b1);
    fetch_req = 1'b0;
    tick();

    // Idle fetch side: loader granted immediately, no fetch_valid
    for (int j = 0; j < 2; j++) begin
      load_valid = 1'b1; load_addr = 10'(5 + j); load_data = 32'hA5A50000 + 32'(j);
      @(negedge clk);
      check("patch_ready", load_ready, 1);
      check("patch_we", mem_we, 1);
      check("patch_gnt", fetch_gnt, 0);
      check("patch_addr", mem_addr, 5 + j);
      @(posedge clk);
      model[5 + j] = 32'hA5A50000 + 32'(j);
      #1;
    end
    load_valid = 1'b0;
    @(negedge clk);
    check("patch_count_frozen", load_count, 4);
    check("patch_idle_we", mem_we, 0);
    check("patch_idle_addr", mem_addr, 6);
    tick();

    // Reload during a fetch stream
    fetch_cycle(10'd0, 1'b1);
    fetch_cycle(10'd1, 1'b1);
    reload = 1'b1; fetch_req = 1'b1; fetch_addr = 10'd3;
    @(negedge clk);
    check("reload_gnt", fetch_gnt, 0);
    check("reload_ready", load_ready, 0);
    check("reload_we", mem_we, 0);
    check("reload_hold_same", cpu_hold, 0);
    tick();
    reload = 1'b0;
    @(negedge clk);
    check("reload_hold", cpu_hold, 1);
    check("reload_count", load_count, 0);
    tick();
    fetch_cycle(10'd3, 1'b0);
    load_valid = 1'b1; load_addr = 10'd0; load_data = 32'hCAFE0000; load_last = 1'b1;
    @(negedge clk);
    check("reboot_ready", load_ready, 1);
    check("reboot_we", mem_we, 1);
    check("reboot_gnt", fetch_gnt, 0);
    check("reboot_addr", mem_addr, 0);
    @(posedge clk);
    model[0] = 32'hCAFE0000;
    #1;
    load_valid = 1'b0; load_last = 1'b0;
    fetch_cycle(10'd0, 1'b1);
    fetch_cycle(10'd3, 1'b1);

    // Asynchronous reset between edges while a fetch is in flight
    fetch_req = 1'b1; fetch_addr = 10'd1;
    @(negedge clk);
    check("pre_rst_gnt", fetch_gnt, 1);
    @(posedge clk);
    #2;
    load_valid = 1'b1; load_addr = 10'd9; load_data = 32'h11;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("arst_hold", cpu_hold, 1);
    check("arst_fetch_valid", fetch_valid, 0);
    check("arst_we", mem_we, 0);
    tick();
    rst_n = 1'b1; load_valid = 1'b0;
    @(negedge clk);
    check("post_rst_hold", cpu_hold, 1);
    check("post_rst_ready", load_ready, 1);
    check("post_rst_gnt", fetch_gnt, 0);
    tick();
    fetch_req = 1'b0;

    // 1025 handshakes with no load_last: load_count saturates at 1024
    for (int i = 0; i <= 1024; i++) begin
      d = $urandom;
      load_valid = 1'b1; load_addr = 10'(i); load_data = d; load_last = 1'b0;
      @(negedge clk);
      check("sat_we", mem_we, 1);
      check("sat_count", load_count, (i < 1024) ? i : 1024);
      @(posedge clk);
      model[i % 1024] = d;
      #1;
    end
    load_valid = 1'b0; fetch_req = 1'b1; fetch_addr = 10'd0;
    @(negedge clk);
    check("sat_final_count", load_count, 1024);
    check("sat_still_load", cpu_hold, 1);
    check("sat_no_gnt", fetch_gnt, 0);
    tick();
    fetch_req = 1'b0;
    d = $urandom;
    load_valid = 1'b1; load_addr = 10'd1000; load_data = d; load_last = 1'b1;
    @(negedge clk);
    check("sat_last_we", mem_we, 1);
    @(posedge clk);
    model[1000] = d;
    #1;
    load_valid = 1'b0; load_last = 1'b0;
    fetch_cycle(10'd1000, 1'b1);
    fetch_cycle(10'd0, 1'b1);
    fetch_cycle(10'd513, 1'b1);
    fetch_req = 1'b0;
    tick();
    tick();
    check("queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
